// File: rtl/x4_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// x4_reg_access_arbiter
//
// Shares the single X4 register-access engine (SPI/PIF/XIF set/get) between
// NREQ requesters. Grants are round-robin. Only one transaction is in flight at
// a time. Each engine strobe lasts a single cycle. A transaction completes on
// eng_done or on a timeout, and the granted requester then receives a one-cycle
// ack.
//
// Parameters
//   NREQ         number of requesters (2..8)
//   TIMEOUT_CYC  cycles spent in WAIT before the transaction aborts with err (>=2)
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   req             per-requester request, held with stable fields until ack
//   req_wr          1 = register write (set), 0 = read (get)
//   req_space       2 bits per requester: 00 SPI, 01 PIF, 10 XIF, 11 invalid
//   req_addr        8 bits per requester, register address
//   req_wdata       8 bits per requester, write data
//   ack             one-cycle completion pulse to the granted requester
//   rdata           read data, valid while ack is high (0 for writes)
//   err             high with ack on timeout or invalid space
//   busy            high in every state except IDLE
//   eng_set_*/eng_get_*   single-cycle engine strobes
//   eng_*_addr      engine address inputs (only the selected space is non-zero)
//   eng_wdata       engine write data
//   eng_rdata       engine read data, valid with eng_done
//   eng_done        engine one-cycle completion pulse
// -----------------------------------------------------------------------------
module x4_reg_access_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [2*NREQ-1:0] req_space,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   ack,
    output logic [7:0]        rdata,
    output logic              err,
    output logic              busy,
    output logic              eng_set_spi,
    output logic              eng_get_spi,
    output logic              eng_set_pif,
    output logic              eng_get_pif,
    output logic              eng_set_xif,
    output logic              eng_get_xif,
    output logic [7:0]        eng_spi_addr,
    output logic [7:0]        eng_pif_addr,
    output logic [7:0]        eng_xif_addr,
    output logic [7:0]        eng_wdata,
    input  logic [7:0]        eng_rdata,
    input  logic              eng_done
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] SP_SPI = 2'b00;
    localparam logic [1:0] SP_PIF = 2'b01;
    localparam logic [1:0] SP_XIF = 2'b10;
    localparam logic [1:0] SP_BAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant;
    logic [CW-1:0]   cnt;
    logic            hold_wr;
    logic [1:0]      hold_space;
    logic [7:0]      hold_addr;
    logic [7:0]      hold_wdata;
    logic [7:0]      rdata_q;
    logic            err_q;

    // Round-robin pick and the picked requester's fields.
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     cand;   // one spare bit so ptr + offset cannot overflow before the wrap
    logic            pick_wr;
    logic [1:0]      pick_space;
    logic [7:0]      pick_addr;
    logic [7:0]      pick_wdata;
    logic            timeout_hit;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        found      = 1'b0;
        pick       = '0;
        cand       = '0;
        pick_wr    = 1'b0;
        pick_space = SP_SPI;
        pick_addr  = '0;
        pick_wdata = '0;

        // First set request at or after the pointer, wrapping NREQ-1 -> 0.
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (pick == IW'(i)) begin
                pick_wr    = req_wr[i];
                pick_space = req_space[2*i +: 2];
                pick_addr  = req_addr[8*i +: 8];
                pick_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    // Next-state and output decode.
    always_comb begin
        state_d      = state;
        ack          = '0;
        rdata        = '0;
        err          = 1'b0;
        busy         = (state != S_IDLE);
        eng_set_spi  = 1'b0;
        eng_get_spi  = 1'b0;
        eng_set_pif  = 1'b0;
        eng_get_pif  = 1'b0;
        eng_set_xif  = 1'b0;
        eng_get_xif  = 1'b0;
        eng_spi_addr = '0;
        eng_pif_addr = '0;
        eng_xif_addr = '0;
        eng_wdata    = '0;

        // Engine inputs stay on the latched values for the whole transaction.
        if (state != S_IDLE) begin
            eng_spi_addr = (hold_space == SP_SPI) ? hold_addr : 8'h00;
            eng_pif_addr = (hold_space == SP_PIF) ? hold_addr : 8'h00;
            eng_xif_addr = (hold_space == SP_XIF) ? hold_addr : 8'h00;
            eng_wdata    = hold_wdata;
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    // An invalid space never reaches the engine.
                    state_d = (pick_space == SP_BAD) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                case (hold_space)
                    SP_SPI:  begin eng_set_spi = hold_wr; eng_get_spi = !hold_wr; end
                    SP_PIF:  begin eng_set_pif = hold_wr; eng_get_pif = !hold_wr; end
                    SP_XIF:  begin eng_set_xif = hold_wr; eng_get_xif = !hold_wr; end
                    default: ;
                endcase
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ack[grant] = 1'b1;
                rdata      = rdata_q;
                err        = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            cnt        <= '0;
            hold_wr    <= 1'b0;
            hold_space <= SP_SPI;
            hold_addr  <= '0;
            hold_wdata <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        hold_wr    <= pick_wr;
                        hold_space <= pick_space;
                        hold_addr  <= pick_addr;
                        hold_wdata <= pick_wdata;
                        rdata_q    <= '0;
                        err_q      <= (pick_space == SP_BAD);
                        rr_ptr     <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    // Completion in the timeout cycle still counts as success.
                    if (eng_done) begin
                        rdata_q <= hold_wr ? 8'h00 : eng_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
